// File: rtl/i2c_line_conditioner.sv
// i2c_line_conditioner
// Front end for the I2C slave: synchronises and deglitches raw SCL/SDA, turns
// the filtered lines into single-cycle edge and START/STOP strobes, tracks the
// bus-busy state and frames bit samples with a 0..8 index within each byte.
// Optional SCL-low timeout is compiled in when I2C_TIMEOUT_EN is defined.
module i2c_line_conditioner #(
  parameter int SYNC_STAGES     = 2,
  parameter int FILTER_LEN      = 4,
  parameter int BUS_FREE_CYCLES = 500,
  parameter int TIMEOUT_CYCLES  = 250000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       i_scl,
  input  logic       i_sda,
  output logic       o_scl,
  output logic       o_sda,
  output logic       o_scl_rise,
  output logic       o_scl_fall,
  output logic       o_start,
  output logic       o_rep_start,
  output logic       o_stop,
  output logic       o_bus_busy,
  output logic       o_bit_valid,
  output logic       o_bit_data,
  output logic [3:0] o_bit_idx,
  output logic       o_ack_slot,
  output logic       o_timeout
);

  localparam int FLT_W  = $clog2(FILTER_LEN + 1);
  localparam int FREE_W = $clog2(BUS_FREE_CYCLES + 1);
  localparam logic [FLT_W-1:0]  FLT_LAST  = FLT_W'(FILTER_LEN - 1);
  localparam logic [FREE_W-1:0] FREE_LAST = FREE_W'(BUS_FREE_CYCLES - 1);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_UNFRAMED,
    ST_ACTIVE,
    ST_FREE_WAIT
  } state_t;

  state_t state_q, state_d;

  logic [SYNC_STAGES-1:0] scl_sync, sda_sync;
  logic                   scl_s, sda_s;
  logic [FLT_W-1:0]       scl_cnt, sda_cnt;
  logic                   scl_flip, sda_flip;
  logic                   ev_scl_rise, ev_scl_fall, ev_start, ev_stop;
  logic                   start_pulse, rep_pulse;
  logic [FREE_W-1:0]      free_cnt;
  logic                   free_hit;
  logic                   timeout_hit;
  logic                   rise_seen;

  assign scl_s = scl_sync[SYNC_STAGES-1];
  assign sda_s = sda_sync[SYNC_STAGES-1];

  // Metastability chains; idle-high lines so they come out of reset as 1.
  always_ff @(posedge clk) begin
    if (reset) begin
      scl_sync <= '1;
      sda_sync <= '1;
    end else begin
      scl_sync <= {scl_sync[SYNC_STAGES-2:0], i_scl};
      sda_sync <= {sda_sync[SYNC_STAGES-2:0], i_sda};
    end
  end

  // A line flips on the edge where its disagreement count completes.
  assign scl_flip = (scl_s != o_scl) && (scl_cnt == FLT_LAST);
  assign sda_flip = (sda_s != o_sda) && (sda_cnt == FLT_LAST);

  // Line events are evaluated against the values the filters are about to take,
  // so the registered strobes line up with the filtered outputs changing.
  assign ev_scl_rise = scl_flip && !o_scl;
  assign ev_scl_fall = scl_flip && o_scl;
  assign ev_start    = sda_flip && o_sda && o_scl && !scl_flip;
  assign ev_stop     = sda_flip && !o_sda && o_scl && !scl_flip;

  // Deglitch filters: count disagreeing samples, flip after FILTER_LEN in a row.
  always_ff @(posedge clk) begin
    if (reset) begin
      o_scl   <= 1'b1;
      o_sda   <= 1'b1;
      scl_cnt <= '0;
      sda_cnt <= '0;
    end else begin
      if (scl_s == o_scl) begin
        scl_cnt <= '0;
      end else if (scl_flip) begin
        o_scl   <= ~o_scl;
        scl_cnt <= '0;
      end else begin
        scl_cnt <= scl_cnt + 1'b1;
      end
      if (sda_s == o_sda) begin
        sda_cnt <= '0;
      end else if (sda_flip) begin
        o_sda   <= ~o_sda;
        sda_cnt <= '0;
      end else begin
        sda_cnt <= sda_cnt + 1'b1;
      end
    end
  end

  // Bus-free qualification: counts idle-high cycles while waiting after STOP.
  assign free_hit = (state_q == ST_FREE_WAIT) && o_scl && o_sda && (free_cnt == FREE_LAST);

  always_ff @(posedge clk) begin
    if (reset) begin
      free_cnt <= '0;
    end else if ((state_q == ST_FREE_WAIT) && o_scl && o_sda) begin
      free_cnt <= free_hit ? '0 : free_cnt + 1'b1;
    end else begin
      free_cnt <= '0;
    end
  end

`ifdef I2C_TIMEOUT_EN
  localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYCLES - 1);

  logic [TO_W-1:0] to_cnt;

  assign timeout_hit = (state_q != ST_IDLE) && !o_scl && (to_cnt == TO_LAST);

  // Stuck-low SCL watchdog; any high SCL or a return to IDLE restarts it.
  always_ff @(posedge clk) begin
    if (reset) begin
      to_cnt    <= '0;
      o_timeout <= 1'b0;
    end else begin
      o_timeout <= timeout_hit;
      if ((state_q != ST_IDLE) && !o_scl) begin
        to_cnt <= timeout_hit ? '0 : to_cnt + 1'b1;
      end else begin
        to_cnt <= '0;
      end
    end
  end
`else
  assign timeout_hit = 1'b0;
  // TIMEOUT_CYCLES only matters with the watchdog compiled in; this is constant 0.
  assign o_timeout = (TIMEOUT_CYCLES < 0);
`endif

  // Bus state register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state and START classification; STOP outranks START, which outranks SCL edges.
  always_comb begin
    state_d     = state_q;
    start_pulse = 1'b0;
    rep_pulse   = 1'b0;
    if (timeout_hit) begin
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (ev_start) begin
            state_d     = ST_ACTIVE;
            start_pulse = 1'b1;
          end else if (ev_scl_fall) begin
            state_d = ST_UNFRAMED;
          end
        end
        ST_UNFRAMED: begin
          if (ev_stop) begin
            state_d = ST_FREE_WAIT;
          end else if (ev_start) begin
            state_d     = ST_ACTIVE;
            start_pulse = 1'b1;
          end
        end
        ST_ACTIVE: begin
          if (ev_stop) begin
            state_d = ST_FREE_WAIT;
          end else if (ev_start) begin
            rep_pulse = 1'b1;
          end
        end
        ST_FREE_WAIT: begin
          if (ev_start) begin
            state_d     = ST_ACTIVE;
            start_pulse = 1'b1;
          end else if (ev_scl_fall) begin
            state_d = ST_UNFRAMED;
          end else if (free_hit) begin
            state_d = ST_IDLE;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  assign o_bus_busy = (state_q != ST_IDLE);
  assign o_ack_slot = (o_bit_idx == 4'd8);

  // Registered line and bus event strobes.
  always_ff @(posedge clk) begin
    if (reset) begin
      o_scl_rise  <= 1'b0;
      o_scl_fall  <= 1'b0;
      o_start     <= 1'b0;
      o_rep_start <= 1'b0;
      o_stop      <= 1'b0;
    end else begin
      o_scl_rise  <= ev_scl_rise;
      o_scl_fall  <= ev_scl_fall;
      o_start     <= start_pulse;
      o_rep_start <= rep_pulse;
      o_stop      <= ev_stop;
    end
  end

  // Bit framing: sample on rise, advance on a fall that follows a rise (skips START hold).
  always_ff @(posedge clk) begin
    if (reset) begin
      o_bit_valid <= 1'b0;
      o_bit_data  <= 1'b0;
      o_bit_idx   <= 4'd0;
      rise_seen   <= 1'b0;
    end else begin
      o_bit_valid <= (state_q == ST_ACTIVE) && ev_scl_rise && !timeout_hit;
      if ((state_q == ST_ACTIVE) && ev_scl_rise) begin
        o_bit_data <= o_sda ^ sda_flip;
      end
      if (timeout_hit || ev_stop) begin
        o_bit_idx <= 4'd0;
        rise_seen <= 1'b0;
      end else if (ev_start) begin
        o_bit_idx <= 4'd0;
        rise_seen <= 1'b0;
      end else if (state_q == ST_ACTIVE) begin
        if (ev_scl_rise) begin
          rise_seen <= 1'b1;
        end else if (ev_scl_fall && rise_seen) begin
          o_bit_idx <= (o_bit_idx == 4'd8) ? 4'd0 : o_bit_idx + 4'd1;
        end
      end
    end
  end

endmodule
